// File: rtl/flag_sequencer_pkg.sv
// Shared constants and types for the flag sequencer: colour width, the black
// level and the two scheduler states.
package flag_sequencer_pkg;

    localparam int COLOR_W = 6;
    localparam logic [COLOR_W-1:0] BLACK = '0;

    typedef enum logic {
        SEQ_SHOW  = 1'b0,
        SEQ_BLANK = 1'b1
    } seq_state_e;

endpackage

// File: rtl/flag_sequencer_frame_debounce.sv
// Frame-rate button debouncer: a press is accepted after DEBOUNCE_FRAMES consecutive
// high samples taken on tick, and is reported once per continuous hold.
module frame_debounce #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    // The counter saturates at DEBOUNCE_FRAMES; that value doubles as the
    // disarmed state, cleared by the next low sample.
    logic [CNT_W-1:0] cnt;

    assign press = tick && level && (cnt == CNT_W'(DEBOUNCE_FRAMES - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            if (!level) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(DEBOUNCE_FRAMES)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flag_sequencer.sv
// Chooses which flag's colour reaches the VGA output, with auto-cycling, debounced
// next/prev buttons and black transition frames; state only moves on frame_tick.
module flag_sequencer
    import flag_sequencer_pkg::*;
#(
    parameter int NUM_FLAGS       = 8,
    parameter int IDX_W           = 3,
    parameter int DWELL_FRAMES    = 300,
    parameter int BLANK_FRAMES    = 8,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic                           btn_next,
    input  logic                           btn_prev,
    input  logic                           auto_en,
    input  logic [NUM_FLAGS*COLOR_W-1:0]   colors_in,
    output logic [COLOR_W-1:0]             color_out,
    output logic [IDX_W-1:0]               flag_sel,
    output logic                           blanking
);

    localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int BLANK_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

    seq_state_e         state;
    logic [DWELL_W-1:0] dwell;
    logic [BLANK_W-1:0] blank_cnt;
    logic [IDX_W-1:0]   target;

    logic press_next, press_prev;
    logic step_fwd, step_back;
    logic show_go;
    logic [IDX_W-1:0] show_tgt, blank_tgt;

    frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_next (
        .clk(clk), .rst(rst), .tick(frame_tick), .level(btn_next), .press(press_next)
    );

    frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_prev (
        .clk(clk), .rst(rst), .tick(frame_tick), .level(btn_prev), .press(press_prev)
    );

    function automatic logic [IDX_W-1:0] wrap_step(input logic [IDX_W-1:0] idx,
                                                   input logic fwd);
        if (fwd) begin
            return (idx == IDX_W'(NUM_FLAGS - 1)) ? '0 : idx + 1'b1;
        end
        return (idx == '0) ? IDX_W'(NUM_FLAGS - 1) : idx - 1'b1;
    endfunction

    // Simultaneous presses cancel; a button step outranks the dwell expiry.
    assign step_fwd  = press_next && !press_prev;
    assign step_back = press_prev && !press_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        show_go   = 1'b0;
        show_tgt  = flag_sel;
        blank_tgt = target;
        show_go   = step_fwd || step_back ||
                    (auto_en && (dwell == DWELL_W'(DWELL_FRAMES - 1)));
        show_tgt  = wrap_step(flag_sel, !step_back);
        if (step_fwd || step_back) begin
            blank_tgt = wrap_step(target, step_fwd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEQ_SHOW;
            flag_sel  <= '0;
            blanking  <= 1'b0;
            dwell     <= '0;
            blank_cnt <= '0;
            target    <= '0;
        end else if (frame_tick) begin
            case (state)
                SEQ_SHOW: begin
                    if (show_go) begin
                        dwell  <= '0;
                        target <= show_tgt;
                        if (BLANK_FRAMES > 0) begin
                            state     <= SEQ_BLANK;
                            blanking  <= 1'b1;
                            blank_cnt <= '0;
                        end else begin
                            flag_sel <= show_tgt;
                        end
                    end else begin
                        dwell <= auto_en ? dwell + 1'b1 : '0;
                    end
                end
                SEQ_BLANK: begin
                    target <= blank_tgt;
                    if (blank_cnt == BLANK_W'(BLANK_FRAMES - 1)) begin
                        flag_sel  <= blank_tgt;
                        blanking  <= 1'b0;
                        dwell     <= '0;
                        blank_cnt <= '0;
                        state     <= SEQ_SHOW;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                default: state <= SEQ_SHOW;
            endcase
        end
    end

    assign color_out = blanking ? BLACK : colors_in[flag_sel*COLOR_W +: COLOR_W];

endmodule
